// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Word-addressed data RAM with programmable access latency and a
//             req/ready handshake, answering core load/store requests.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        Busy
);

    localparam int         c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [31:0]        r_mem [DEPTH];

    logic [1:0]         r_state;
    logic [3:0]         r_count;
    logic               r_we;
    logic               r_err;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_ready;
    logic               r_merr;
    logic               r_busy;

    logic               w_zero_lat;
    logic               w_in_idle;
    logic               w_req_err;
    logic [c_IDX_W-1:0] w_req_idx;
    logic               w_commit;
    logic               w_acc_we;
    logic               w_acc_err;
    logic [c_IDX_W-1:0] w_acc_idx;
    logic [31:0]        w_acc_wdata;
    logic [31:0]        w_load_data;

    generate
        if (LATENCY == 0) begin : g_zero_lat
            assign w_zero_lat = 1'b1;
        end else begin : g_wait_lat
            assign w_zero_lat = 1'b0;
        end
    endgenerate

    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_req_err = (Addr[1:0] != 2'b00) || ({2'b00, Addr[31:2]} >= 32'(DEPTH));
    assign w_req_idx = Addr[c_IDX_W+1:2];

    // With zero latency the access commits on the accepting edge itself, so the
    // live request is the access; otherwise the captured copy is.
    assign w_commit    = (w_in_idle && MemReq && w_zero_lat) ||
                         ((r_state == c_ST_WAIT) && (r_count == 4'd0));
    assign w_acc_we    = w_in_idle ? MemWrite  : r_we;
    assign w_acc_err   = w_in_idle ? w_req_err : r_err;
    assign w_acc_idx   = w_in_idle ? w_req_idx : r_idx;
    assign w_acc_wdata = w_in_idle ? WData     : r_wdata;
    assign w_load_data = (!w_acc_we && !w_acc_err) ? r_mem[w_acc_idx] : 32'd0;

    // Contents are never cleared, but a reset must suppress a store that would
    // otherwise commit on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && w_commit && w_acc_we && !w_acc_err) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_count <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_merr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_rdata <= 32'd0;
                    r_ready <= 1'b0;
                    r_merr  <= 1'b0;
                    if (MemReq) begin
                        r_we    <= MemWrite;
                        r_err   <= w_req_err;
                        r_idx   <= w_req_idx;
                        r_wdata <= WData;
                        r_busy  <= 1'b1;
                        if (w_zero_lat) begin
                            r_state <= c_ST_RESP;
                            r_ready <= 1'b1;
                            r_merr  <= w_acc_err;
                            r_rdata <= w_load_data;
                        end else begin
                            r_state <= c_ST_WAIT;
                            r_count <= c_CNT_INIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state <= c_ST_RESP;
                        r_ready <= 1'b1;
                        r_merr  <= w_acc_err;
                        r_rdata <= w_load_data;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_rdata <= 32'd0;
                    r_ready <= 1'b0;
                    r_merr  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_rdata <= 32'd0;
                    r_ready <= 1'b0;
                    r_merr  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ReadData = r_rdata;
    assign MemReady = r_ready;
    assign MemErr   = r_merr;
    assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Randomized scoreboard bench for data_mem_responder, driving a
//             LATENCY=2 instance and a LATENCY=0 instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];
    logic        busy  [2];

    logic [31:0] mem_m [2][DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(reset), .MemReq(req[0]), .MemWrite(we[0]),
        .Addr(addr[0]), .WData(wdata[0]), .ReadData(rdata[0]),
        .MemReady(ready[0]), .MemErr(err[0]), .Busy(busy[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .MemReq(req[1]), .MemWrite(we[1]),
        .Addr(addr[1]), .WData(wdata[1]), .ReadData(rdata[1]),
        .MemReady(ready[1]), .MemErr(err[1]), .Busy(busy[1])
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a plain array per instance, updated in request order.
    task automatic push_expect(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit   bad;
        int   idx;
        bad    = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        e.err  = bad;
        e.data = 32'd0;
        if (!bad) begin
            idx = int'(a[31:2]);
            if (w) mem_m[d][idx] = wd;
            else   e.data = mem_m[d][idx];
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Issues one request; exp_edges is 2 when the call starts in the RESP cycle
    // of a held previous request, since acceptance must wait for IDLE.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input int exp_edges);
        int edges;
        int lat;
        int exp_lat;
        exp_lat  = (d == 0) ? LAT0 : LAT1;
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        push_expect(d, w, a, wd);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (busy[d] !== 1'b1 && edges < 10);
        check($sformatf("accept_edges[%0d]", d), 32'(edges), 32'(exp_edges));
        we[d]    = 1'($urandom);
        addr[d]  = $urandom;
        wdata[d] = $urandom;
        lat = 0;
        while (ready[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency[%0d]", d), 32'(lat), 32'(exp_lat));
        if (!hold) begin
            req[d] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   n;
        for (int d = 0; d < 2; d++) begin
            if (ready[d] === 1'b1) begin
                n = (d == 0) ? q0.size() : q1.size();
                if (n == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready[%0d]: MemReady=1 got, 0 expected (nothing outstanding)", d);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("rdata[%0d]", d), rdata[d], e.data);
                    check($sformatf("err[%0d]", d), 32'(err[d]), 32'(e.err));
                end
            end else begin
                check($sformatf("idle_rdata[%0d]", d), rdata[d], 32'd0);
                check($sformatf("idle_err[%0d]", d), 32'(err[d]), 32'd0);
            end
        end
    end

    initial begin
        bit          w;
        bit          hold;
        bit          prev_hold;
        int          r;
        logic [31:0] a;

        for (int d = 0; d < 2; d++) begin
            req[d]   = 1'b1;
            we[d]    = 1'b1;
            addr[d]  = 32'h40;
            wdata[d] = 32'hA5A5A5A5;
        end
        repeat (3) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'd0);
                check($sformatf("rst_ready[%0d]", d), 32'(ready[d]), 32'd0);
                check($sformatf("rst_rdata[%0d]", d), rdata[d], 32'd0);
                check($sformatf("rst_err[%0d]", d), 32'(err[d]), 32'd0);
            end
        end
        req[1] = 1'b0;
        reset  = 1'b0;

        // Basic store/load, then fill the rest of both RAMs.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 1);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(d == 0 && i == 4)) txn(d, 1'b1, 32'(4 * i), $urandom, 1'b0, 1);
            end
        end

        // Rejected accesses leave RAM alone; 4*DEPTH aliases word 0 in the index bits.
        txn(0, 1'b0, 32'h12, 32'h0, 1'b0, 1);
        txn(0, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0, 1);
        txn(0, 1'b1, 32'(4 * DEPTH), 32'hBAD0BAD0, 1'b0, 1);
        txn(0, 1'b1, 32'h11, 32'hBAD1BAD1, 1'b0, 1);
        txn(0, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 1);

        // Back-to-back stores with MemReq held through RESP.
        txn(0, 1'b1, 32'h0, 32'h01234567, 1'b1, 1);
        txn(0, 1'b1, 32'(4 * (DEPTH - 1)), 32'h89ABCDEF, 1'b0, 2);
        txn(0, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        txn(0, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 1'b0, 1);

        // Reset during WAIT discards the store.
        txn(0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h22222222;
        @(posedge clk); #1;
        check("abort_accepted", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        check("abort_still_wait", 32'(ready[0]), 32'd0);
        reset = 1'b1;
        #2;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_ready", 32'(ready[0]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        reset  = 1'b0;
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 1);

        // Zero-latency instance: inputs scrambled after acceptance.
        txn(1, 1'b0, 32'h1C, 32'h0, 1'b0, 1);
        txn(1, 1'b1, 32'h1C, 32'hCAFEF00D, 1'b0, 1);
        txn(1, 1'b0, 32'h1C, 32'h0, 1'b0, 1);
        txn(1, 1'b0, 32'h13, 32'h0, 1'b0, 1);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            prev_hold = 1'b0;
            for (int k = 0; k < 120; k++) begin
                w = 1'($urandom);
                r = $urandom_range(0, 9);
                if (r == 0)      a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                else if (r == 1) a = 32'(4 * $urandom_range(DEPTH, 4000));
                else if (r == 2) a = $urandom | 32'h8000_0000;
                else             a = 32'(4 * $urandom_range(0, DEPTH - 1));
                hold = ($urandom_range(0, 3) == 0);
                txn(d, w, a, $urandom, hold, prev_hold ? 2 : 1);
                prev_hold = hold;
            end
            if (prev_hold) begin
                req[d] = 1'b0;
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
